// File: rtl/gap_pkg.sv
// Shared types and helpers for the global average pool head (optional build macro GAP_ROUND_EN).
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package gap_pkg;

  localparam int unsigned DATA_W = `DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } gap_state_e;

  // Accumulator must hold the sum of a full frame without wrapping.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned fm);
    return dw + int'($clog2(fm * fm));
  endfunction

  function automatic int unsigned cnt_width(input int unsigned fm);
    return int'($clog2(fm * fm + 1));
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_dw(input logic signed [63:0] x);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (DATA_W - 1));
    if (x > hi) return DATA_W'(hi);
    if (x < lo) return DATA_W'(lo);
    return DATA_W'(x);
  endfunction

endpackage

// File: rtl/global_avgpool_head_scale_sat.sv
// One channel of reciprocal multiply, optional round-half-up (GAP_ROUND_EN), shift and saturate.
module gap_scale_sat
  import gap_pkg::*;
#(
  parameter int unsigned ACC_W     = 26,
  parameter int unsigned AVG_MULT  = 84,
  parameter int unsigned AVG_SHIFT = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] scaled_c
);

  localparam int unsigned MW = $clog2(AVG_MULT + 1) + 1;
  localparam int unsigned PW = ACC_W + MW;
  localparam int unsigned RW = PW + 1;
  localparam logic signed [MW-1:0] MULT = MW'(AVG_MULT);

`ifdef GAP_ROUND_EN
  localparam logic signed [RW-1:0] RND = RW'(1) << (AVG_SHIFT - 1);
`else
  localparam logic signed [RW-1:0] RND = '0;
`endif

  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] shifted;

  // Extra bit in the biased sum keeps the rounding add from overflowing.
  always_comb begin
    prod     = PW'(acc) * PW'(MULT);
    biased   = RW'(prod) + RND;
    shifted  = biased >>> AVG_SHIFT;
    scaled_c = sat_dw(64'(shifted));
  end

endmodule

// File: rtl/global_avgpool_head.sv
// Per-frame global average pool: accumulates every channel over a frame and emits one
// scaled, saturated vector with a single-cycle valid. Rounding selected by GAP_ROUND_EN.
module global_avgpool_head
  import gap_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM = 256,
  parameter int unsigned FM_WIDTH    = 28,
  parameter int unsigned AVG_MULT    = 84,
  parameter int unsigned AVG_SHIFT   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     vs,
  input  logic                     data_e,
  input  logic signed [DATA_W-1:0] data_in  [CHANNEL_NUM-1:0],
  output logic signed [DATA_W-1:0] data_out [CHANNEL_NUM-1:0],
  output logic                     data_e_out,
  output logic                     frame_err
);

  localparam int unsigned NPIX   = FM_WIDTH * FM_WIDTH;
  localparam int unsigned ACC_W  = acc_width(DATA_W, FM_WIDTH);
  localparam int unsigned CW     = cnt_width(FM_WIDTH);
  localparam bit          SINGLE = (NPIX == 1);

  gap_state_e state, state_d;
  logic [CW-1:0] count;
  logic signed [ACC_W-1:0] acc [CHANNEL_NUM-1:0];
  logic signed [DATA_W-1:0] scaled [CHANNEL_NUM-1:0];
  logic vs_pend, vs_pend_d;
  logic acc_clr, acc_load, acc_add, err_c, cap, fire;
  logic clear_all;

  assign clear_all = rst || !mode;

  always_ff @(posedge clk) begin
    if (clear_all) state <= IDLE;
    else           state <= state_d;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state;
    vs_pend_d = vs_pend;
    acc_clr   = 1'b0;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    err_c     = 1'b0;
    cap       = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (vs) begin
          acc_clr  = 1'b1;
          acc_load = data_e;
          state_d  = (data_e && SINGLE) ? SCALE : ACCUM;
        end else if (data_e) begin
          err_c = 1'b1;
        end
      end
      ACCUM: begin
        if (vs) begin
          acc_clr  = 1'b1;
          acc_load = data_e;
          err_c    = 1'b1;
          state_d  = (data_e && SINGLE) ? SCALE : ACCUM;
        end else if (data_e) begin
          acc_add = 1'b1;
          if (count == CW'(NPIX - 1)) state_d = SCALE;
        end
      end
      SCALE: begin
        cap     = 1'b1;
        err_c   = data_e;
        state_d = OUT;
        if (vs) vs_pend_d = 1'b1;
      end
      OUT: begin
        fire      = 1'b1;
        err_c     = data_e;
        vs_pend_d = 1'b0;
        if (vs || vs_pend) begin
          acc_clr = 1'b1;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
    gap_scale_sat #(
      .ACC_W    (ACC_W),
      .AVG_MULT (AVG_MULT),
      .AVG_SHIFT(AVG_SHIFT)
    ) u_scale_sat (
      .acc     (acc[g]),
      .scaled_c(scaled[g])
    );
  end

  always_ff @(posedge clk) begin
    if (clear_all) begin
      count      <= '0;
      vs_pend    <= 1'b0;
      data_e_out <= 1'b0;
      frame_err  <= 1'b0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        acc[c]      <= '0;
        data_out[c] <= '0;
      end
    end else begin
      vs_pend    <= vs_pend_d;
      data_e_out <= fire;
      frame_err  <= err_c;
      if (acc_clr)      count <= acc_load ? CW'(1) : '0;
      else if (acc_add) count <= count + CW'(1);
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        if (acc_clr)      acc[c] <= acc_load ? ACC_W'(data_in[c]) : '0;
        else if (acc_add) acc[c] <= acc[c] + ACC_W'(data_in[c]);
        if (cap)          data_out[c] <= scaled[c];
      end
    end
  end

endmodule
